seq_divider6: RTL and testbench

//  Sequential signed divider; the inverse datapath of the 6-bit MAC.

---
 rtl/seq_divider6.sv | 78 +++++++
 tb/tb_seq_divider6.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_divider6.sv
// seq_divider6: radix-2 restoring signed divider, 12-bit dividend by 6-bit divisor, one quotient bit per clock.
module seq_divider6 #(
    parameter int DW = 12,
    parameter int VW = 6,
    parameter int QW = DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic          div0
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [DW-1:0] acc;
    logic [VW-1:0] dvs;
    logic [VW:0]   pr;
    logic          neg_n, neg_d;
    logic [VW+1:0] t, diff;
    logic          ge;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // t stays below 2^(VW+1), so the top bit of diff is the borrow of t - |divisor|
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        t         = {pr, acc[DW-1]};
        diff      = t - {2'b00, dvs};
        ge        = ~diff[VW+1];
        state_n   = (state == IDLE) ? (in_valid ? CALC : IDLE) :
                    (state == CALC) ? (cnt == '0 ? SIGN : CALC) :
                    (state == SIGN) ? DONE :
                    (out_ready ? IDLE : DONE);
    end

    // acc starts as |dividend| and fills with quotient bits as dividend bits shift out
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            quot <= '0;
            rem  <= '0;
            div0 <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                neg_n <= dividend[DW-1];
                neg_d <= divisor[VW-1];
                acc   <= dividend[DW-1] ? -dividend : dividend;
                dvs   <= divisor[VW-1] ? -divisor : divisor;
                pr    <= '0;
                cnt   <= CW'(DW - 1);
            end
            if (state == CALC) begin
                pr  <= ge ? diff[VW:0] : t[VW:0];
                acc <= {acc[DW-2:0], ge};
                cnt <= cnt - 1'b1;
            end
            if (state == SIGN) begin
                div0 <= dvs == '0;
                quot <= (dvs == '0) ? '0 : (neg_n ^ neg_d) ? -{1'b0, acc} : {1'b0, acc};
                rem  <= (dvs == '0) ? '0 : neg_n ? -pr[VW-1:0] : pr[VW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_seq_divider6.sv
// tb_seq_divider6: directed corners plus a random sweep against an integer-division reference.
module tb_seq_divider6;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, div0;
    logic [11:0] dividend = '0;
    logic [5:0]  divisor = '0;
    logic [12:0] quot;
    logic [5:0]  rem;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    seq_divider6 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quot(quot), .rem(rem), .div0(div0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SV integer division truncates toward zero and % takes the dividend's sign
    function automatic void model(input int a, input int b, output logic [12:0] q,
                                  output logic [5:0] r, output logic z);
        int qi, ri;
        z = b == 0;
        qi = z ? 0 : a / b;
        ri = z ? 0 : a % b;
        q = qi[12:0];
        r = ri[5:0];
    endfunction

    task automatic run_op(input logic [11:0] a, input logic [5:0] b, input int stall);
        logic [12:0] eq;
        logic [5:0]  er;
        logic        ez;
        int          lat, id;
        model(int'($signed(a)), int'($signed(b)), eq, er, ez);
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = stall == 0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom);
            dividend = 12'($urandom);
            divisor  = 6'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'd14);
        check("quot", 32'(quot), 32'(eq));
        check("rem", 32'(rem), 32'(er));
        check("div0", 32'(div0), 32'(ez));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (!ez) begin
            id = int'($signed(quot)) * int'($signed(b)) + int'($signed(rem));
            check("identity", 32'(id), 32'(int'($signed(a))));
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_quot", 32'(quot), 32'(eq));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("drop_valid", 32'(out_valid), 32'd0);
        check("back_in_ready", 32'(in_ready), 32'd1);
        check("keep_rem", 32'(rem), 32'(er));
    endtask

    initial begin
        logic [11:0] ra;
        logic [5:0]  rb;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_div0", 32'(div0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(12'd100, 6'd7, 0);
        run_op(12'hF9C, 6'd7, 0);
        run_op(12'd100, 6'h39, 2);
        run_op(12'h800, 6'h3F, 0);
        run_op(12'h800, 6'h20, 1);
        run_op(12'd37, 6'd0, 0);
        run_op(12'd100, 6'd7, 5);

        in_valid = 1'b1;
        dividend = 12'd500;
        divisor  = 6'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_quot", 32'(quot), 32'd0);
        repeat (16) @(negedge clk);
        check("mid_rst_no_result", 32'(out_valid), 32'd0);
        run_op(12'd2047, 6'd31, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 12'($urandom);
            rb = ($urandom % 6 == 0) ? 6'd0 : 6'($urandom);
            run_op(ra, rb, int'($urandom % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
